plug_seq: RTL and testbench
===========================

PLUG_SEQ -- requirements
Module: plug_seq

Interface
REQ-001 Parameter LEN_W, default 16, width of each phase length and of the beat counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle request to run one frame sequence.
REQ-005 abort  input  1  terminate the current sequence immediately.
REQ-006 skip_len  input  LEN_W  input beats to discard.
REQ-007 pass_len  input  LEN_W  beats to forward input to output.
REQ-008 pad_len  input  LEN_W  beats to emit forced-valid output.
REQ-009 ivalid  input  1  upstream valid, observed for beat counting.
REQ-010 oready  input  1  downstream ready, observed for beat counting.
REQ-011 state  output  4  one-hot plug state: 0001 SKIP, 0010 PASS, 0100 PAD, 1000 IDLE.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-014 FSM states SHALL be IDLE, SKIP, PASS, PAD; state SHALL be a direct register, one-hot, never zero or multi-hot.
REQ-015 In IDLE with start=1, skip_len, pass_len and pad_len SHALL be latched; start outside IDLE SHALL be ignored.
REQ-016 After start, state SHALL enter the first phase in order SKIP, PASS, PAD with nonzero length, on the next cycle; zero-length phases are skipped without spending a cycle.
REQ-017 All three lengths zero: state SHALL stay IDLE and done SHALL pulse on the cycle after start.
REQ-018 Beat qualifiers: SKIP counts ivalid; PASS counts ivalid&oready; PAD counts oready.
REQ-019 Counter SHALL load phase length on entry and decrement once per qualifying beat; at most one beat per cycle.
REQ-020 On the qualifying beat that brings the counter to zero, state SHALL advance on the next edge to the next nonzero phase, or to IDLE.
REQ-021 done SHALL assert for exactly one cycle, in the first IDLE cycle after a normally completed sequence.
REQ-022 abort=1 SHALL force IDLE on the next edge from any state, with no done pulse; abort has priority over start and beat counting.
REQ-023 abort and start together in IDLE: start SHALL be ignored.
REQ-024 Maximum phase length is 2^LEN_W-1 beats; no wrap-around. The counter never decrements below zero.

Reset
REQ-025 On rst=1 at a clock edge: state=1000 (IDLE), counter=0, latched lengths=0, busy=0, done=0.
REQ-026 rst mid-sequence SHALL abandon the sequence without a done pulse; rst overrides abort and start.

Configuration
REQ-027 Macro PLUG_SEQ_PAD_EN defined: PAD phase per REQ-016..020.
REQ-028 PLUG_SEQ_PAD_EN undefined: pad_len is ignored, PAD is never entered, state never equals 0100, and PASS completion goes directly to IDLE.

Structure
REQ-029 Shared package plug_pkg SHALL hold the four one-hot state encodings and the default LEN_W.
REQ-030 One sub-module, plug_seq_cnt, SHALL hold the loadable LEN_W down-counter with a zero flag. FSM and output logic remain in plug_seq.
REQ-031 state connects unmodified to the plug stage's state input; plug_seq contains no datapath.

Verification
REQ-032 skip=2, pass=3, pad=1, ivalid=oready=1 throughout -> SKIP 2 cycles, PASS 3, PAD 1, IDLE with done pulse; busy high 6 cycles.
REQ-033 skip=0, pass=4, pad=0, oready low for 2 cycles mid-PASS -> PASS lasts 6 cycles, counter holds while stalled, then done.
REQ-034 All lengths zero, start -> state stays 1000, busy stays 0, done pulses on the next cycle.
REQ-035 skip=5, abort asserted on the 3rd SKIP cycle -> IDLE next cycle, no done; a start 1 cycle later runs a fresh sequence.
REQ-036 start re-pulsed during PASS -> ignored, original lengths complete; with PLUG_SEQ_PAD_EN undefined, pad=2 -> 0100 never observed.
REQ-037 rst asserted during PAD -> state=1000, busy=0, done=0 on the next cycle.

Source files
------------

// File: rtl/plug_pkg.sv
// Shared definitions for the plug sequencer: one-hot state encodings and default beat-counter width.
package plug_pkg;

   localparam int LEN_W_DEF = 16;

   typedef enum logic [3:0] {
      ST_SKIP = 4'b0001,
      ST_PASS = 4'b0010,
      ST_PAD  = 4'b0100,
      ST_IDLE = 4'b1000
   } plug_state_e;

endpackage

// File: rtl/plug_seq_cnt.sv
// Loadable down-counter for phase beats; saturates at zero and flags the zero state.
module plug_seq_cnt
   import plug_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LEN_W-1:0] load_val,
   input  logic             dec,
   output logic [LEN_W-1:0] cnt,
   output logic             zero
);

   logic [LEN_W-1:0] cnt_r;

   // Load has priority over decrement; decrement never wraps below zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != '0)) begin
         cnt_r <= cnt_r - LEN_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt  = cnt_r;
   assign zero = (cnt_r == '0);

endmodule

// File: rtl/plug_seq.sv
// Plug-stage sequencer: runs SKIP -> PASS -> PAD phases of programmable beat length.
// The PAD phase exists only when PLUG_SEQ_PAD_EN is defined.
module plug_seq
   import plug_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] skip_len,
   input  logic [LEN_W-1:0] pass_len,
   input  logic [LEN_W-1:0] pad_len,
   input  logic             ivalid,
   input  logic             oready,
   output logic [3:0]       state,
   output logic             busy,
   output logic             done
);

`ifdef PLUG_SEQ_PAD_EN
   localparam logic PAD_EN = 1'b1;
`else
   localparam logic PAD_EN = 1'b0;
`endif

   plug_state_e      state_r, state_nxt_s;
   logic             busy_r, done_r, done_nxt_s;
   logic [LEN_W-1:0] pass_r, pad_r, pad_len_s;
   logic             cnt_load_s, cnt_dec_s, cnt_zero_s;
   logic [LEN_W-1:0] cnt_load_val_s, cnt_s;
   logic             beat_s, last_s;

   // With PAD disabled the pad length is forced to zero so PAD is never chosen.
   assign pad_len_s = pad_len & {LEN_W{PAD_EN}};

   plug_seq_cnt #(.LEN_W(LEN_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load_s),
      .load_val (cnt_load_val_s),
      .dec      (cnt_dec_s),
      .cnt      (cnt_s),
      .zero     (cnt_zero_s)
   );

   // Beat qualifier for the active phase.
   always_comb begin
      beat_s = 1'b0;
      case (state_r)
         ST_SKIP: beat_s = ivalid;
         ST_PASS: beat_s = ivalid & oready;
         ST_PAD:  beat_s = oready;
         default: beat_s = 1'b0;
      endcase
   end

   assign last_s    = beat_s & (cnt_s == LEN_W'(1));
   assign cnt_dec_s = beat_s & ~cnt_zero_s & ~abort;

   // Next-state, counter load and completion decode.
   always_comb begin
      state_nxt_s    = state_r;
      cnt_load_s     = 1'b0;
      cnt_load_val_s = '0;
      done_nxt_s     = 1'b0;
      if (abort) begin
         state_nxt_s = ST_IDLE;
         cnt_load_s  = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && (skip_len != '0)) begin
                  state_nxt_s    = ST_SKIP;
                  cnt_load_s     = 1'b1;
                  cnt_load_val_s = skip_len;
               end else if (start && (pass_len != '0)) begin
                  state_nxt_s    = ST_PASS;
                  cnt_load_s     = 1'b1;
                  cnt_load_val_s = pass_len;
               end else if (start && (pad_len_s != '0)) begin
                  state_nxt_s    = ST_PAD;
                  cnt_load_s     = 1'b1;
                  cnt_load_val_s = pad_len_s;
               end else if (start) begin
                  done_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_SKIP: begin
               if (last_s && (pass_r != '0)) begin
                  state_nxt_s    = ST_PASS;
                  cnt_load_s     = 1'b1;
                  cnt_load_val_s = pass_r;
               end else if (last_s && (pad_r != '0)) begin
                  state_nxt_s    = ST_PAD;
                  cnt_load_s     = 1'b1;
                  cnt_load_val_s = pad_r;
               end else if (last_s) begin
                  state_nxt_s = ST_IDLE;
                  done_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_SKIP;
               end
            end
            ST_PASS: begin
               if (last_s && (pad_r != '0)) begin
                  state_nxt_s    = ST_PAD;
                  cnt_load_s     = 1'b1;
                  cnt_load_val_s = pad_r;
               end else if (last_s) begin
                  state_nxt_s = ST_IDLE;
                  done_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_PASS;
               end
            end
            ST_PAD: begin
               if (last_s) begin
                  state_nxt_s = ST_IDLE;
                  done_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_PAD;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Later-phase lengths are captured only when a sequence is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_r <= '0;
         pad_r  <= '0;
      end else if ((state_r == ST_IDLE) && start && !abort) begin
         pass_r <= pass_len;
         pad_r  <= pad_len_s;
      end else begin
         pass_r <= pass_r;
         pad_r  <= pad_r;
      end
   end

   // State and status registers; busy is registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         done_r  <= done_nxt_s;
      end
   end

   assign state = state_r;
   assign busy  = busy_r;
   assign done  = done_r;

endmodule

// File: tb/tb_plug_seq.sv
// Scoreboard bench for plug_seq: a queue-of-phases model predicts state/busy/done each cycle.
module tb_plug_seq;

   localparam int LW = 16;
   localparam logic [3:0] S_SKIP = 4'b0001;
   localparam logic [3:0] S_PASS = 4'b0010;
   localparam logic [3:0] S_PAD  = 4'b0100;
   localparam logic [3:0] S_IDLE = 4'b1000;
`ifdef PLUG_SEQ_PAD_EN
   localparam bit PAD_ON = 1'b1;
`else
   localparam bit PAD_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, start, abort, ivalid, oready;
   logic [LW-1:0] skip_len, pass_len, pad_len;
   logic [3:0]    state;
   logic          busy, done;

   always #5 clk = ~clk;

   plug_seq #(.LEN_W(LW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .skip_len (skip_len),
      .pass_len (pass_len),
      .pad_len  (pad_len),
      .ivalid   (ivalid),
      .oready   (oready),
      .state    (state),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      logic [3:0] st;
      int         rem;
   } ph_t;

   typedef struct {
      logic [3:0] st;
      logic       busy;
      logic       done;
   } exp_t;

   ph_t  mq[$];
   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   end_chk  = 1'b0;
   bit   end_done = 1'b0;

   function automatic logic qual(input logic [3:0] st, input logic iv, input logic rdy);
      case (st)
         S_SKIP:  return iv;
         S_PASS:  return iv & rdy;
         S_PAD:   return rdy;
         default: return 1'b0;
      endcase
   endfunction

   task automatic setl(input int a, input int b, input int c);
      skip_len = LW'(a);
      pass_len = LW'(b);
      pad_len  = LW'(c);
   endtask

   // Drive one cycle of inputs, advance the model, and queue the post-edge expectation.
   task automatic step(input logic st_i, input logic ab_i, input logic iv_i,
                       input logic rdy_i, input logic rst_i);
      exp_t e;
      ph_t  h;
      logic d;
      rst = rst_i; start = st_i; abort = ab_i; ivalid = iv_i; oready = rdy_i;
      d = 1'b0;
      if (rst_i || ab_i) begin
         mq.delete();
      end else if (mq.size() == 0) begin
         if (st_i) begin
            if (skip_len != 0) begin h.st = S_SKIP; h.rem = int'(skip_len); mq.push_back(h); end
            if (pass_len != 0) begin h.st = S_PASS; h.rem = int'(pass_len); mq.push_back(h); end
            if (PAD_ON && pad_len != 0) begin h.st = S_PAD; h.rem = int'(pad_len); mq.push_back(h); end
            if (mq.size() == 0) d = 1'b1;
         end
      end else begin
         h = mq[0];
         if (qual(h.st, iv_i, rdy_i)) begin
            h.rem = h.rem - 1;
            if (h.rem == 0) begin
               void'(mq.pop_front());
               if (mq.size() == 0) d = 1'b1;
            end else begin
               mq[0] = h;
            end
         end
      end
      e.st   = (mq.size() == 0) ? S_IDLE : mq[0].st;
      e.busy = (mq.size() != 0);
      e.done = d;
      @(posedge clk);
      sb.push_back(e);
      #1;
   endtask

   // Monitor: compare DUT outputs against queued expectations away from the active edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         n_checks++;
         if (state !== mon_e.st) begin
            n_errors++;
            $display("FAIL state: got %b expected %b at %0t", state, mon_e.st, $time);
         end
         n_checks++;
         if (busy !== mon_e.busy) begin
            n_errors++;
            $display("FAIL busy: got %b expected %b at %0t", busy, mon_e.busy, $time);
         end
         n_checks++;
         if (done !== mon_e.done) begin
            n_errors++;
            $display("FAIL done: got %b expected %b at %0t", done, mon_e.done, $time);
         end
      end
      if (end_chk && !end_done) begin
         end_done = 1'b1;
         n_checks++;
         if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
         end
      end
   end

   initial begin
      setl(0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Full run with continuous beats.
      setl(2, 3, 1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      // PASS only, downstream stalls mid-phase.
      setl(0, 4, 0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      // All-zero lengths.
      setl(0, 0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Abort on the third SKIP cycle, then a fresh start.
      setl(5, 1, 1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (9) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      // Abort together with start in IDLE.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      // Start re-pulsed during PASS with different lengths.
      setl(1, 3, 2);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      setl(4, 4, 4);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      // Reset during PAD (or trailing phase when PAD is disabled).
      setl(0, 1, 3);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0)
            setl($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8));
         else
            setl($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 49) == 0),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 299) == 0));
      end
      end_chk = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
